multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control sequencer for the MIPS-subset datapath (ADD/SUB/SLT/JR, J/JAL, ADDI/XORI, BEQ/BNE, LW/SW).
//  Replaces the single-cycle combinational decode. Walks each instruction through fetch/decode/execute/memory/writeback
//  over a shared, handshaked instruction/data memory port. Emits per-cycle enables to PC, IR, regfile, ALU and muxes.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting for mem_ack before entering ERR; 0 = no timeout
// PORTS
//  clk                       in   1  single clock, rising edge
//  reset                     in   1  synchronous, active-high
//  opcode                    in   6  IR[31:26], valid from DECODE onward
//  funct                     in   6  IR[5:0]
//  zero                      in   1  ALU zero flag
//  mem_ack                   in   1  memory done; sampled only while mem_req=1
//  mem_req                   out  1  memory access request
//  mem_we                    out  1  1=store, qualifies mem_req
//  mem_addr_sel              out  1  0=PC, 1=ALU result
//  ir_we                     out  1  load IR
//  pc_we                     out  1  load PC
//  pc_src                    out  2  0=PC+4, 1=branch target, 2=jump target, 3=r[rs]
//  wr_en_reg                 out  1  regfile write
//  write_to_rt               out  1  dest=rt (else rd)
//  write_reg_31              out  1  dest=r31
//  write_pc8_to_reg          out  1  wdata=PC+8
//  write_from_memory_to_reg  out  1  wdata=MDR
//  use_signextimm            out  1  ALU B=signext imm (else rt)
//  ALU_Signal                out  3  0 ADD,1 SUB,2 XOR,3 SLT
//  err                       out  1  sticky: timeout (or illegal instr, see CONFIGURATION)
// BEHAVIOUR
//  - reset=1: state<=IDLE, timeout counter<=0, err<=0. Mid-instruction reset aborts; no write issued in the reset cycle.
//  - Moore outputs decoded from state; any output not listed for a state is 0. IDLE: all outputs 0 -> FETCH next cycle.
//  - FETCH: mem_req=1, mem_addr_sel=0. Hold until mem_ack=1; in the ack cycle ir_we=1, pc_we=1, pc_src=0 -> DECODE.
//  - DECODE: route on opcode/funct: ADD/SUB/SLT->EXEC_R; ADDI/XORI->EXEC_I; LW/SW->MEM_ADDR; BEQ/BNE->BRANCH;
//    J/JAL->JUMP; R-type JR->JUMPREG; anything else->FETCH (NOP).
//  - EXEC_R: ALU_Signal per funct -> WB_R (wr_en_reg=1, same ALU_Signal) -> FETCH.
//  - EXEC_I: use_signextimm=1, ALU ADD/XOR -> WB_I (wr_en_reg, write_to_rt, same ALU ctl) -> FETCH.
//  - MEM_ADDR: ADD, use_signextimm=1 -> MEM_RD (LW) / MEM_WR (SW).
//  - MEM_RD/MEM_WR: mem_req=1, mem_addr_sel=1, mem_we=(MEM_WR), ADD+use_signextimm held; wait ack.
//    MEM_RD ack -> WB_MEM (wr_en_reg, write_to_rt, write_from_memory_to_reg) -> FETCH. MEM_WR ack -> FETCH.
//  - BRANCH: ALU_Signal=SUB, pc_src=1, pc_we = BEQ ? zero : ~zero -> FETCH.
//  - JUMP: pc_src=2, pc_we=1; JAL also wr_en_reg, write_reg_31, write_pc8_to_reg -> FETCH. JUMPREG: pc_src=3, pc_we=1.
//  - Latency (ack same cycle as req): R/I 4, LW 5, SW 4, branch/jump 3 cycles incl. FETCH.
//  - Timeout: counter clears on entry to FETCH/MEM_RD/MEM_WR, increments per cycle without ack; reaching
//    TIMEOUT_CYCLES -> ERR. Ack in the same cycle as the limit wins (no error).
//  - ERR: all outputs 0 except err=1; exits only via reset. Late mem_ack ignored.
//  - State register: 4 bits, one-hot not required; unreachable codes -> IDLE.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unsupported opcode/funct in DECODE -> ERR (err=1, core halts).
//  Undefined: unsupported instruction is a NOP (DECODE -> FETCH), err only from timeout.
// STRUCTURE
//  Shared package mips_ctrl_pkg: opcode/funct codes, ALU_Signal codes, pc_src codes, state encoding.
//  One sub-module: mem_timeout_ctr (load/clear, enable, hit flag). Next-state and output decode stay in this file.
// TESTING
//  - ADD, ack same cycle: FETCH,DECODE,EXEC_R,WB_R; wr_en_reg=1 only in cycle 4, ALU_Signal=0; pc_we pulse cycle 1.
//  - LW with mem_ack delayed 3 cycles in MEM_RD: mem_req high 4 cycles, write_from_memory_to_reg=1 in WB_MEM only.
//  - BEQ zero=1 -> pc_we=1,pc_src=1; BNE zero=1 -> pc_we=0; JAL -> wr_en_reg,write_reg_31,write_pc8_to_reg in JUMP.
//  - No ack, TIMEOUT_CYCLES=4: err=1 after 4 FETCH cycles, stays 1 with later ack; reset clears, IDLE then FETCH.
//  - Opcode 6'h3F: with ILLEGAL_TRAP_EN err=1; without, back to FETCH, no write enables ever asserted.
//  - Reset asserted in MEM_WR: mem_req=0 next cycle, no mem_we pulse, restart fetch sequence cleanly.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_src_e;

  // Code 4'hF is unused and recovers to IDLE
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_JUMPREG  = 4'd13,
    ST_ERR      = 4'd14
  } state_e;

  // ALU operation for the arithmetic R-type functs; callers filter legality
  function automatic alu_op_e r_alu_op(input logic [5:0] fn);
    alu_op_e op;
    op = ALU_ADD;
    if (fn == FN_SUB) op = ALU_SUB;
    if (fn == FN_SLT) op = ALU_SLT;
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_tmo.sv
// Memory-wait timeout counter: counts consecutive un-acked request cycles.
// Latency: hit is combinational in the cycle the count would reach LIMIT.
// Backpressure: none; clr has priority over en, LIMIT=0 never hits.
module mem_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on state entry, step on each un-acked wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (LIMIT > 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath (Moore outputs per state).
// Latency: R/I 4, LW 5, SW 4, branch/jump 3 cycles incl. FETCH when mem_ack returns with mem_req.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ack; TIMEOUT_CYCLES without ack -> ERR.
// Build option ILLEGAL_TRAP_EN: unsupported instructions trap to ERR instead of acting as NOPs.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       wr_en_reg,
  output logic       write_to_rt,
  output logic       write_reg_31,
  output logic       write_pc8_to_reg,
  output logic       write_from_memory_to_reg,
  output logic       use_signextimm,
  output logic [2:0] ALU_Signal,
  output logic       err
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ST_ILLEGAL = ST_ERR;
`else
  localparam state_e ST_ILLEGAL = ST_FETCH;
`endif

  state_e  state_q, state_d;
  logic    tmo_hit, tmo_clr, tmo_en, mem_wait;
  logic    r_arith;
  logic    mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c;
  logic    wr_en_c, wrt_c, wr31_c, wpc8_c, wfm_c, sext_c, err_c;
  pc_src_e pc_src_c;
  alu_op_e alu_c;

  assign r_arith  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign tmo_en   = mem_wait && !mem_ack;
  assign tmo_clr  = (state_d != state_q);

  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_src_c   = PC_PLUS4;
    wr_en_c    = 1'b0;
    wrt_c      = 1'b0;
    wr31_c     = 1'b0;
    wpc8_c     = 1'b0;
    wfm_c      = 1'b0;
    sext_c     = 1'b0;
    alu_c      = ALU_ADD;
    err_c      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (r_arith)               state_d = ST_EXEC_R;
            else if (funct == FN_JR)   state_d = ST_JUMPREG;
            else                       state_d = ST_ILLEGAL;
          end
          OP_ADDI, OP_XORI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
          OP_J, OP_JAL:     state_d = ST_JUMP;
          default:          state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: begin
        alu_c   = r_alu_op(funct);
        state_d = ST_WB_R;
      end
      ST_WB_R: begin
        alu_c   = r_alu_op(funct);
        wr_en_c = 1'b1;
        state_d = ST_FETCH;
      end
      ST_EXEC_I: begin
        sext_c  = 1'b1;
        alu_c   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d = ST_WB_I;
      end
      ST_WB_I: begin
        sext_c  = 1'b1;
        alu_c   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        wr_en_c = 1'b1;
        wrt_c   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        sext_c  = 1'b1;
        state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD, ST_MEM_WR: begin
        mem_req_c  = 1'b1;
        mem_we_c   = (state_q == ST_MEM_WR);
        addr_sel_c = 1'b1;
        sext_c     = 1'b1;
        if (mem_ack)      state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_WB_MEM: begin
        wr_en_c = 1'b1;
        wrt_c   = 1'b1;
        wfm_c   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_c    = ALU_SUB;
        pc_src_c = PC_BRANCH;
        pc_we_c  = (opcode == OP_BEQ) ? zero : !zero;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_c = PC_JUMP;
        pc_we_c  = 1'b1;
        if (opcode == OP_JAL) begin
          wr_en_c = 1'b1;
          wr31_c  = 1'b1;
          wpc8_c  = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_JUMPREG: begin
        pc_src_c = PC_REG;
        pc_we_c  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ERR: err_c = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset aborts in the same cycle: no request, write or register update leaks out
  assign mem_req                  = mem_req_c  && !reset;
  assign mem_we                   = mem_we_c   && !reset;
  assign mem_addr_sel             = addr_sel_c && !reset;
  assign ir_we                    = ir_we_c    && !reset;
  assign pc_we                    = pc_we_c    && !reset;
  assign pc_src                   = reset ? 2'd0 : pc_src_c;
  assign wr_en_reg                = wr_en_c    && !reset;
  assign write_to_rt              = wrt_c      && !reset;
  assign write_reg_31             = wr31_c     && !reset;
  assign write_pc8_to_reg         = wpc8_c     && !reset;
  assign write_from_memory_to_reg = wfm_c      && !reset;
  assign use_signextimm           = sext_c     && !reset;
  assign ALU_Signal               = reset ? 3'd0 : alu_c;
  assign err                      = err_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream with random memory latency.
// Expected per-cycle outputs come from an instruction-level model and are queued.
// A negedge monitor pops and compares one expectation per cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       err;
    logic [2:0] alu;
    logic       sext;
    logic       wfm;
    logic       wpc8;
    logic       wr31;
    logic       wrt;
    logic       wr_en;
    logic [1:0] pc_src;
    logic       pc_we;
    logic       ir_we;
    logic       addr_sel;
    logic       mem_we;
    logic       mem_req;
  } out_t;

  typedef struct packed {
    out_t v;
    out_t m;
  } exp_t;

  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_JR = 3, K_J = 4, K_JAL = 5;
  localparam int K_ADDI = 6, K_XORI = 7, K_BEQ = 8, K_BNE = 9, K_LW = 10, K_SW = 11;
  localparam int K_BAD = 12, K_ILL3F = 13;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ack;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       wr_en_reg, write_to_rt, write_reg_31, write_pc8_to_reg;
  logic       write_from_memory_to_reg, use_signextimm, err;
  logic [2:0] ALU_Signal;

  out_t  dut_o;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;
  int    total = 0;
  int    bad = 0;
  out_t  all_m;
  out_t  noerr_m;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .opcode                   (opcode),
    .funct                    (funct),
    .zero                     (zero),
    .mem_ack                  (mem_ack),
    .mem_req                  (mem_req),
    .mem_we                   (mem_we),
    .mem_addr_sel             (mem_addr_sel),
    .ir_we                    (ir_we),
    .pc_we                    (pc_we),
    .pc_src                   (pc_src),
    .wr_en_reg                (wr_en_reg),
    .write_to_rt              (write_to_rt),
    .write_reg_31             (write_reg_31),
    .write_pc8_to_reg         (write_pc8_to_reg),
    .write_from_memory_to_reg (write_from_memory_to_reg),
    .use_signextimm           (use_signextimm),
    .ALU_Signal               (ALU_Signal),
    .err                      (err)
  );

  always #5 clk = ~clk;

  assign dut_o = {err, ALU_Signal, use_signextimm, write_from_memory_to_reg, write_pc8_to_reg,
                  write_reg_31, write_to_rt, wr_en_reg, pc_src, pc_we, ir_we, mem_addr_sel,
                  mem_we, mem_req};

  // Monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      total++;
      if ((dut_o & mon_e.m) !== (mon_e.v & mon_e.m)) begin
        bad++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t",
                 mon_nm, dut_o, mon_e.v, mon_e.m, $time);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be during it
  task automatic step(input logic ack, input logic z, input logic rst,
                      input out_t v, input out_t m, input string nm);
    mem_ack = ack;
    zero    = z;
    reset   = rst;
    exp_q.push_back('{v: v, m: m});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // n reset cycles (all outputs quiet, err unknown) then the IDLE cycle
  task automatic do_reset(input int n);
    out_t o;
    o = '0;
    for (int i = 0; i < n; i++) step(rb(), rb(), 1'b1, o, noerr_m, "reset_quiet");
    step(rb(), rb(), 1'b0, o, all_m, "idle_after_reset");
  endtask

  task automatic set_instr(input int k);
    logic [5:0] bad_ops [3];
    bad_ops[0] = 6'h3F; bad_ops[1] = 6'h0C; bad_ops[2] = 6'h00;
    funct = 6'($urandom_range(0, 63));
    case (k)
      K_ADD:   begin opcode = 6'h00; funct = 6'h20; end
      K_SUB:   begin opcode = 6'h00; funct = 6'h22; end
      K_SLT:   begin opcode = 6'h00; funct = 6'h2A; end
      K_JR:    begin opcode = 6'h00; funct = 6'h08; end
      K_J:     opcode = 6'h02;
      K_JAL:   opcode = 6'h03;
      K_ADDI:  opcode = 6'h08;
      K_XORI:  opcode = 6'h0E;
      K_BEQ:   opcode = 6'h04;
      K_BNE:   opcode = 6'h05;
      K_LW:    opcode = 6'h23;
      K_SW:    opcode = 6'h2B;
      K_ILL3F: opcode = 6'h3F;
      default: begin
        opcode = bad_ops[$urandom_range(0, 2)];
        if (opcode == 6'h00) funct = 6'h21;
      end
    endcase
  endtask

  // Reference model: expected outputs for one whole instruction, cycle by cycle
  task automatic run_instr(input int k, input int df, input int dm, input logic bz);
    out_t o;
    set_instr(k);
    for (int i = 0; i < df; i++) begin
      o = '0; o.mem_req = 1'b1;
      step(1'b0, rb(), 1'b0, o, all_m, "fetch_wait");
    end
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    step(1'b1, rb(), 1'b0, o, all_m, "fetch_ack");
    o = '0;
    step(rb(), rb(), 1'b0, o, all_m, "decode");
    case (k)
      K_ADD, K_SUB, K_SLT: begin
        o = '0;
        o.alu = (k == K_SUB) ? 3'd1 : (k == K_SLT) ? 3'd3 : 3'd0;
        step(rb(), rb(), 1'b0, o, all_m, "exec_r");
        o.wr_en = 1'b1;
        step(rb(), rb(), 1'b0, o, all_m, "wb_r");
      end
      K_ADDI, K_XORI: begin
        o = '0; o.sext = 1'b1; o.alu = (k == K_XORI) ? 3'd2 : 3'd0;
        step(rb(), rb(), 1'b0, o, all_m, "exec_i");
        o.wr_en = 1'b1; o.wrt = 1'b1;
        step(rb(), rb(), 1'b0, o, all_m, "wb_i");
      end
      K_LW, K_SW: begin
        o = '0; o.sext = 1'b1;
        step(rb(), rb(), 1'b0, o, all_m, "mem_addr");
        o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (k == K_SW);
        for (int i = 0; i < dm; i++) step(1'b0, rb(), 1'b0, o, all_m, "mem_wait");
        step(1'b1, rb(), 1'b0, o, all_m, "mem_ack");
        if (k == K_LW) begin
          o = '0; o.wr_en = 1'b1; o.wrt = 1'b1; o.wfm = 1'b1;
          step(rb(), rb(), 1'b0, o, all_m, "wb_mem");
        end
      end
      K_BEQ, K_BNE: begin
        o = '0; o.alu = 3'd1; o.pc_src = 2'd1;
        o.pc_we = (k == K_BEQ) ? bz : !bz;
        step(rb(), bz, 1'b0, o, all_m, "branch");
      end
      K_J, K_JAL: begin
        o = '0; o.pc_src = 2'd2; o.pc_we = 1'b1;
        if (k == K_JAL) begin o.wr_en = 1'b1; o.wr31 = 1'b1; o.wpc8 = 1'b1; end
        step(rb(), rb(), 1'b0, o, all_m, "jump");
      end
      K_JR: begin
        o = '0; o.pc_src = 2'd3; o.pc_we = 1'b1;
        step(rb(), rb(), 1'b0, o, all_m, "jumpreg");
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        o = '0; o.err = 1'b1;
        step(rb(), rb(), 1'b0, o, all_m, "illegal_err");
        step(1'b1, rb(), 1'b0, o, all_m, "illegal_err_hold");
        do_reset(1);
`endif
      end
    endcase
  endtask

  initial begin
    out_t o;
    int   nk;
    all_m   = '1;
    noerr_m = '1;
    noerr_m.err = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    nk = 12;
`else
    nk = 13;
`endif
    opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ack = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed cases from the feature list
    run_instr(K_ADD, 0, 0, 1'b0);
    run_instr(K_LW, 0, 3, 1'b0);
    run_instr(K_BEQ, 0, 0, 1'b1);
    run_instr(K_BNE, 0, 0, 1'b1);
    run_instr(K_BEQ, 1, 0, 1'b0);
    run_instr(K_BNE, 0, 0, 1'b0);
    run_instr(K_JAL, 1, 0, 1'b0);
    run_instr(K_SW, 3, 3, 1'b0);
    run_instr(K_XORI, 2, 0, 1'b0);
    run_instr(K_JR, 0, 0, 1'b0);

    // Random instruction stream; waits of 0..3 stay inside the 4-cycle limit
    for (int n = 0; n < 250; n++) begin
      run_instr($urandom_range(0, nk - 1), $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    // Unsupported opcode 6'h3F
    run_instr(K_ILL3F, 0, 0, 1'b0);
    run_instr(K_ADD, 0, 0, 1'b0);

    // Reset while a store is waiting for memory
    set_instr(K_SW);
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    step(1'b1, rb(), 1'b0, o, all_m, "sw_fetch_ack");
    o = '0;
    step(1'b0, rb(), 1'b0, o, all_m, "sw_decode");
    o.sext = 1'b1;
    step(1'b0, rb(), 1'b0, o, all_m, "sw_mem_addr");
    o.mem_req = 1'b1; o.mem_we = 1'b1; o.addr_sel = 1'b1;
    step(1'b0, rb(), 1'b0, o, all_m, "sw_mem_wait");
    o = '0;
    step(1'b1, rb(), 1'b1, o, noerr_m, "sw_reset_abort");
    step(1'b0, rb(), 1'b0, o, all_m, "sw_idle_after_abort");
    run_instr(K_ADD, 0, 0, 1'b0);

    // Fetch never acknowledged: ERR after 4 cycles, sticky against a late ack
    set_instr(K_ADD);
    o = '0; o.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, rb(), 1'b0, o, all_m, "tmo_fetch_wait");
    o = '0; o.err = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, rb(), 1'b0, o, all_m, "tmo_err_sticky");
    do_reset(1);
    run_instr(K_SUB, 0, 0, 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
